// File: rtl/base_pkg.sv
// Shared types and helpers for the base_* arbitration/mux blocks.
package base_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Index width for n items, never below 1 so single-entry blocks still get a port.
    function automatic int base_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/base_rr_pick.sv
// Combinational rotating-priority pick: first asserted req at or after ptr, wrapping.
module base_rr_pick
    import base_pkg::*;
#(
    parameter int n  = 4,
    parameter int sw = base_clog2(n)
) (
    input  logic [n-1:0]  req,
    input  logic [sw-1:0] ptr,
    output logic [n-1:0]  gnt,
    output logic [sw-1:0] idx,
    output logic          any
);

    int          pos;
    logic [sw-1:0] pos_s;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        pos_s = '0;
        for (int off = 0; off < n; off++) begin
            // ptr < n always, so a single subtract implements the wrap.
            pos = int'(ptr) + off;
            if (pos >= n) pos = pos - n;
            pos_s = sw'(pos);
            if (!any && req[pos_s]) begin
                any        = 1'b1;
                gnt[pos_s] = 1'b1;
                idx        = pos_s;
            end
        end
    end

endmodule

// File: rtl/base_rrarb_mux.sv
// Round-robin arbiter muxing ni valid/ready requesters onto one registered output stage,
// with optional packet lock from the first beat to the end-of-packet beat.
//
//  state      | meaning
//  -----------+----------------------------------------------------------
//  ARB_IDLE   | rotating-priority arbitration starting at ptr
//  ARB_LOCKED | grant pinned to lk_idx until its end-of-packet beat moves
module base_rrarb_mux
    import base_pkg::*;
#(
    parameter int ni    = 4,
    parameter int width = 8,
    parameter int lock  = 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [ni-1:0]               i_v,
    output logic [ni-1:0]               i_r,
    input  logic [ni*width-1:0]         i_d,
    input  logic [ni-1:0]               i_e,
    output logic                        o_v,
    input  logic                        o_r,
    output logic [width-1:0]            o_d,
    output logic                        o_e,
    output logic [base_clog2(ni)-1:0]   o_s
);

    localparam int sw = base_clog2(ni);

    arb_state_e       state;
    logic [sw-1:0]    ptr;
    logic [sw-1:0]    lk_idx;
    logic [ni-1:0]    req;
    logic [ni-1:0]    gnt;
    logic [sw-1:0]    idx;
    logic             any;
    logic             ld;
    logic             xfer;
    logic [sw-1:0]    ptr_nxt;
    logic [width-1:0] sel_d;
    logic             sel_e;

    // Grant never looks at o_r; o_r only gates ready through ld.
    always_comb begin
        req = i_v;
        if (state == ARB_LOCKED) begin
            req         = '0;
            req[lk_idx] = i_v[lk_idx];
        end
    end

    base_rr_pick #(
        .n  (ni),
        .sw (sw)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (gnt),
        .idx (idx),
        .any (any)
    );

    assign ld      = ~o_v | o_r;
    assign i_r     = (ld & reset_n) ? gnt : '0;
    assign xfer    = any & ld;
    assign ptr_nxt = (idx == sw'(ni - 1)) ? '0 : idx + 1'b1;

    always_comb begin
        sel_d = '0;
        for (int k = 0; k < ni; k++) begin
            if (gnt[k]) sel_d = i_d[k*width +: width];
        end
        sel_e = |(i_e & gnt);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ARB_IDLE;
            ptr    <= '0;
            lk_idx <= '0;
            o_v    <= 1'b0;
            o_d    <= '0;
            o_e    <= 1'b0;
            o_s    <= '0;
        end else begin
            if (xfer) begin
                o_v <= 1'b1;
                o_d <= sel_d;
                o_e <= sel_e;
                o_s <= idx;
                ptr <= ptr_nxt;
                if (lock != 0 && !sel_e) begin
                    state  <= ARB_LOCKED;
                    lk_idx <= idx;
                end else begin
                    state <= ARB_IDLE;
                end
            end else if (o_r) begin
                o_v <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    // A requester left waiting must still be valid on the next cycle.
    logic [ni-1:0] pend_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pend_q <= '0;
        else          pend_q <= i_v & ~i_r;
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert ((pend_q & ~i_v) == '0)
            else $error("base_rrarb_mux: requester dropped valid before ready, pend=%b v=%b",
                        pend_q, i_v);
        end
    end
`endif

endmodule

// File: tb/tb_base_rrarb_mux.sv
// Directed bench for base_rrarb_mux: one locking instance and one non-locking instance.
module tb_base_rrarb_mux;

    logic        clk;
    logic        reset_n;

    logic [3:0]  i_v, i_r, i_e;
    logic [31:0] i_d;
    logic        o_v, o_r, o_e;
    logic [7:0]  o_d;
    logic [1:0]  o_s;

    logic [3:0]  n_i_v, n_i_r, n_i_e;
    logic [31:0] n_i_d;
    logic        n_o_v, n_o_r, n_o_e;
    logic [7:0]  n_o_d;
    logic [1:0]  n_o_s;

    int vectors;
    int miscompares;

    base_rrarb_mux #(.ni(4), .width(8), .lock(1)) u_lk (
        .clk (clk), .reset_n (reset_n),
        .i_v (i_v), .i_r (i_r), .i_d (i_d), .i_e (i_e),
        .o_v (o_v), .o_r (o_r), .o_d (o_d), .o_e (o_e), .o_s (o_s)
    );

    base_rrarb_mux #(.ni(4), .width(8), .lock(0)) u_nl (
        .clk (clk), .reset_n (reset_n),
        .i_v (n_i_v), .i_r (n_i_r), .i_d (n_i_d), .i_e (n_i_e),
        .o_v (n_o_v), .o_r (n_o_r), .o_d (n_o_d), .o_e (n_o_e), .o_s (n_o_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requester k carries byte b+k.
    task automatic set_d(input logic [7:0] b);
        i_d = {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n = 1'b0;
        i_v = 4'b1111; i_e = 4'b1111; o_r = 1'b1; set_d(8'h00);
        n_i_v = 4'b0000; n_i_e = 4'b0101; n_o_r = 1'b1;
        n_i_d = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_v", o_v, 0);
        chk("rst_i_r", i_r, 0);
        chk("rst_o_s", o_s, 0);
        chk("rst_o_d", o_d, 0);
        chk("rst_nl_o_v", n_o_v, 0);
        reset_n = 1'b1;

        // release: rotating grants on the locking instance, single-beat packets
        for (int s = 0; s < 4; s++) begin
            i_v = 4'(4'b1111 << s);
            #1 chk("t1_i_r", i_r, 32'(4'b0001 << s));
            edge1();
            chk("t1_o_v", o_v, 1);
            chk("t1_o_s", o_s, s);
            chk("t1_o_d", o_d, s);
        end
        i_v = 4'b0000;
        edge1();
        chk("t1_drain_o_v", o_v, 0);

        // non-locking instance: all valid, i_e ignored for arbitration but passed through
        for (int s = 0; s < 12; s++) begin
            n_i_v = (s < 8) ? 4'b1111 : 4'(4'b1111 << (s - 8));
            #1 chk("t2_i_r", n_i_r, 32'(1 << (s % 4)));
            edge1();
            chk("t2_o_s", n_o_s, s % 4);
            chk("t2_o_d", n_o_d, 8'hA0 + 8'(8'h11 * (s % 4)));
            chk("t2_o_e", n_o_e, ((s % 4) % 2 == 0) ? 1 : 0);
        end
        n_i_v = 4'b0000;
        edge1();
        chk("t2_drain_o_v", n_o_v, 0);

        // packet lock on requester 1 while requester 2 waits (ptr=0)
        i_v = 4'b0110; i_e = 4'b0000; set_d(8'h40);
        #1 chk("t3a_i_r", i_r, 4'b0010);
        edge1();
        chk("t3a_o_s", o_s, 1);
        chk("t3a_o_d", o_d, 8'h41);
        chk("t3a_o_e", o_e, 0);
        i_v = 4'b0100;
        #1 chk("t3b_lock_idle_i_r", i_r, 4'b0000);
        edge1();
        chk("t3b_o_v", o_v, 0);
        i_v = 4'b0110; set_d(8'h50);
        #1 chk("t3c_i_r", i_r, 4'b0010);
        edge1();
        chk("t3c_o_s", o_s, 1);
        chk("t3c_o_d", o_d, 8'h51);
        i_e = 4'b0010; set_d(8'h60);
        #1 chk("t3d_i_r", i_r, 4'b0010);
        edge1();
        chk("t3d_o_s", o_s, 1);
        chk("t3d_o_e", o_e, 1);
        chk("t3d_o_d", o_d, 8'h61);
        i_v = 4'b0100; i_e = 4'b0100;
        #1 chk("t3e_i_r", i_r, 4'b0100);
        edge1();
        chk("t3e_o_s", o_s, 2);
        chk("t3e_o_e", o_e, 1);
        chk("t3e_o_d", o_d, 8'h62);
        i_v = 4'b0000;
        edge1();

        // backpressure (ptr=3)
        i_v = 4'b0001; i_e = 4'b0001; set_d(8'h40);
        #1 chk("t4_first_i_r", i_r, 4'b0001);
        edge1();
        chk("t4_first_o_s", o_s, 0);
        chk("t4_first_o_d", o_d, 8'h40);
        o_r = 1'b0; i_v = 4'b0011; i_e = 4'b0011; set_d(8'h70);
        for (int c = 0; c < 5; c++) begin
            #1 chk("t4_hold_i_r", i_r, 4'b0000);
            edge1();
            chk("t4_hold_o_v", o_v, 1);
            chk("t4_hold_o_d", o_d, 8'h40);
            chk("t4_hold_o_s", o_s, 0);
        end
        o_r = 1'b1;
        #1 chk("t4_resume_i_r", i_r, 4'b0010);
        edge1();
        chk("t4_resume_o_s", o_s, 1);
        chk("t4_resume_o_d", o_d, 8'h71);
        i_v = 4'b0001;
        #1 chk("t4_last_i_r", i_r, 4'b0001);
        edge1();
        chk("t4_last_o_s", o_s, 0);
        chk("t4_last_o_d", o_d, 8'h70);
        i_v = 4'b0000;
        edge1();
        chk("t4_drain_o_v", o_v, 0);

        // wrap-around (ptr=1)
        i_v = 4'b1000; i_e = 4'b1111; set_d(8'h80);
        #1 chk("t5_g3_i_r", i_r, 4'b1000);
        edge1();
        chk("t5_g3_o_s", o_s, 3);
        chk("t5_g3_o_d", o_d, 8'h83);
        i_v = 4'b1001;
        #1 chk("t5_wrap_i_r", i_r, 4'b0001);
        edge1();
        chk("t5_wrap_o_s", o_s, 0);
        chk("t5_wrap_o_d", o_d, 8'h80);
        i_v = 4'b1000;
        #1 chk("t5_tail_i_r", i_r, 4'b1000);
        edge1();
        chk("t5_tail_o_s", o_s, 3);
        i_v = 4'b0000;
        edge1();

        // reset in the middle of a locked packet from requester 2 (ptr=0)
        i_v = 4'b0100; i_e = 4'b0000; set_d(8'h90);
        #1 chk("t6_lock_i_r", i_r, 4'b0100);
        edge1();
        chk("t6_lock_o_s", o_s, 2);
        chk("t6_lock_o_v", o_v, 1);
        reset_n = 1'b0; i_v = 4'b0101; i_e = 4'b0101;
        #1 chk("t6_rst_o_v", o_v, 0);
        chk("t6_rst_i_r", i_r, 4'b0000);
        chk("t6_rst_o_s", o_s, 0);
        edge1();
        reset_n = 1'b1;
        #1 chk("t6_rel_i_r", i_r, 4'b0001);
        edge1();
        chk("t6_rel_o_s", o_s, 0);
        chk("t6_rel_o_d", o_d, 8'h90);
        i_v = 4'b0100;
        #1 chk("t6_next_i_r", i_r, 4'b0100);
        edge1();
        chk("t6_next_o_s", o_s, 2);
        chk("t6_next_o_e", o_e, 1);
        chk("t6_next_o_d", o_d, 8'h92);
        i_v = 4'b0000;
        edge1();
        chk("t6_drain_o_v", o_v, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
